// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive buffer between the UART receiver and the APB register block.
// Each received character is stored with its parity and stop-bit error
// flags. The oldest entry is presented show-ahead on rd_*. Fill-level
// status, a threshold interrupt, a sticky overrun flag and an idle
// timeout are also reported so software can drain partial frames.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   tick_i                baud oversampling tick (one clk wide)
//   flush_i               empties the FIFO (overrun flag kept)
//   wr_valid_i, wr_*      character strobe, data and error flags
//   rd_en_i               pop strobe; rd_* show the head entry
//   empty_o, full_o       fill status
//   count_o               fill level 0..DEPTH
//   threshold_i           interrupt level 1..DEPTH (0 acts as 1)
//   thresh_irq_o          count_o >= effective threshold
//   overrun_o             sticky, a character was dropped while full
//   overrun_clr_i         clears overrun_o (a new drop wins)
//   timeout_o             TIMEOUT_TICKS ticks idle with data pending
module uart_rx_fifo #(
   parameter  int DEPTH         = 16,
   parameter  int TIMEOUT_TICKS = 64,
   localparam int CW            = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          tick_i,
   input  logic          flush_i,
   input  logic          wr_valid_i,
   input  logic [7:0]    wr_data_i,
   input  logic          wr_parity_err_i,
   input  logic          wr_stop_bit_err_i,
   input  logic          rd_en_i,
   output logic [7:0]    rd_data_o,
   output logic          rd_parity_err_o,
   output logic          rd_stop_bit_err_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [CW-1:0] count_o,
   input  logic [CW-1:0] threshold_i,
   output logic          thresh_irq_o,
   output logic          overrun_o,
   input  logic          overrun_clr_i,
   output logic          timeout_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q, count_nxt, thr_eff;
   logic          empty_q, full_q, irq_q, ovr_q;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic          push, pop, drop;
   logic [9:0]    head;

   // A pop frees the slot in the same cycle, so a push at full is accepted
   // when paired with a pop.
   assign pop  = rd_en_i & ~empty_q;
   assign push = wr_valid_i & (~full_q | pop);
   assign drop = wr_valid_i & full_q & ~pop & ~flush_i;

   assign thr_eff = (threshold_i == '0) ? CW'(1) : threshold_i;

   always_comb begin
      count_nxt = count_q;
      if (flush_i)
         count_nxt = '0;
      else if (push && !pop)
         count_nxt = count_q + CW'(1);
      else if (pop && !push)
         count_nxt = count_q - CW'(1);
   end

   // Idle counter: any activity, flush or an empty FIFO restarts it.
   always_comb begin
      tcnt_nxt = tcnt;
      if (flush_i || push || pop || empty_q)
         tcnt_nxt = '0;
      else if (tick_i && tcnt != TW'(TIMEOUT_TICKS))
         tcnt_nxt = tcnt + TW'(1);
   end

   // Storage is not reset; the read side is gated while empty instead.
   always_ff @(posedge clk) begin
      if (reset_n && push && !flush_i)
         mem[wr_ptr] <= {wr_stop_bit_err_i, wr_parity_err_i, wr_data_i};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         irq_q   <= 1'b0;
         tcnt    <= '0;
      end else begin
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
         count_q <= count_nxt;
         empty_q <= (count_nxt == '0);
         full_q  <= (count_nxt == CW'(DEPTH));
         irq_q   <= (count_nxt >= thr_eff);
         tcnt    <= tcnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         ovr_q <= 1'b0;
      else if (drop)
         ovr_q <= 1'b1;
      else if (overrun_clr_i)
         ovr_q <= 1'b0;
   end

   assign head = empty_q ? 10'd0 : mem[rd_ptr];
   assign {rd_stop_bit_err_o, rd_parity_err_o, rd_data_o} = head;

   assign empty_o      = empty_q;
   assign full_o       = full_q;
   assign count_o      = count_q;
   assign thresh_irq_o = irq_q;
   assign overrun_o    = ovr_q;
   assign timeout_o    = (tcnt == TW'(TIMEOUT_TICKS));

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between the UART receiver and the APB register interface. Captures each received character with its parity and stop-bit error flags, holds up to DEPTH entries, and presents the oldest entry show-ahead to the register block. Also reports fill-level status, a programmable threshold interrupt, a sticky overrun flag and an idle-timeout flag, so software can drain partial frames.

## Interface
- DEPTH, 16, number of entries; power of two, ≥ 2
- TIMEOUT_TICKS, 64, tick_i pulses of inactivity with a non-empty FIFO before timeout_o asserts (64 = 4 bit times at 16x oversampling)
- CW, $clog2(DEPTH)+1, width of count and threshold fields (derived, not overridden)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous and active-low, sampled on rising clk
- tick_i  in  1  baud oversampling tick, one clk wide
- flush_i  in  1  empties the FIFO
- wr_valid_i  in  1  character strobe from receiver, one clk wide
- wr_data_i  in  8  received character, right-aligned
- wr_parity_err_i  in  1  parity error for this character
- wr_stop_bit_err_i  in  1  stop-bit error for this character
- rd_en_i  in  1  pop strobe from APB read of RX data register
- rd_data_o  out  8  head entry data
- rd_parity_err_o  out  1  head entry parity flag
- rd_stop_bit_err_o  out  1  head entry stop-bit flag
- empty_o  out  1  no entries
- full_o  out  1  DEPTH entries
- count_o  out  CW  current fill level, 0..DEPTH
- threshold_i  in  CW  interrupt level, 1..DEPTH (0 treated as 1)
- thresh_irq_o  out  1  count_o ≥ effective threshold
- overrun_o  out  1  sticky: a character was dropped while full
- overrun_clr_i  in  1  clears overrun_o
- timeout_o  out  1  idle timeout with data pending

## Operation
- Storage: DEPTH × 10-bit entries {stop_err, parity_err, data}; write and read pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; count register of CW bits.
- Push = wr_valid_i & (~full_o | pop). Pop = rd_en_i & ~empty_o.
- Push on full without simultaneous pop: character dropped, memory and pointers unchanged, overrun_o set.
- Push and pop in same cycle: both occur, count unchanged, including at full (push accepted). At empty only the push occurs; pop ignored.
- Pop on empty: ignored, no flag.
- flush_i: pointers and count to 0, timeout counter cleared, timeout_o cleared; overrun_o unaffected. flush_i has priority over push/pop in the same cycle (incoming character discarded, no overrun).
- overrun_o: set has priority over overrun_clr_i in the same cycle.
- Timeout: counter increments on tick_i while FIFO non-empty, saturates at TIMEOUT_TICKS. Cleared on push, pop, flush, or when empty. timeout_o = 1 when counter == TIMEOUT_TICKS; drops the cycle after any clearing event.
- rd_* outputs are valid only when empty_o = 0; value when empty is don't-care but must not be X after reset (memory need not be reset; outputs gated to 0 when empty).

## Timing
- Reset (reset_n low at rising clk): pointers, count, timeout counter = 0; empty_o = 1, full_o = 0, count_o = 0, thresh_irq_o = 0, overrun_o = 0, timeout_o = 0, rd_* = 0. Reset mid-operation discards all content.
- All status outputs registered; update the cycle after the causing edge.
- Push at edge N: count_o, empty_o, full_o, thresh_irq_o reflect it after edge N; written entry visible on rd_* after edge N if it became head (write-to-read latency 1 cycle).
- Pop at edge N: next entry on rd_* after edge N.
- thresh_irq_o derived from next-state count; no extra cycle beyond count_o.
- Overrun: overrun_o high after the edge of the dropped push.

## Test plan
- Reset, push 0x41,0x42,0x43 (flags 0) -> count_o 3, rd_data_o 0x41; pop ×3 returns 0x41,0x42,0x43 in order, empty_o = 1 after third pop.
- Push 0x55 with wr_parity_err_i=1, then 0xAA with wr_stop_bit_err_i=1 -> head shows 0x55/parity 1/stop 0; after pop 0xAA/parity 0/stop 1.
- Fill 16 entries (0x00..0x0F), push 0xFF -> full_o 1, overrun_o 1, count_o 16, drain yields 0x00..0x0F; pulse overrun_clr_i -> overrun_o 0; simultaneous push+pop at full -> count stays 16, last entry 0x10 read last.
- threshold_i = 4: after 3 pushes thresh_irq_o 0, after 4th push 1, after one pop 0; threshold_i = 0 -> irq after first push.
- One entry, no activity, 64 tick_i pulses -> timeout_o 1 after 64th tick, not after 63rd; pop -> timeout_o 0 next cycle.
- 20 push/pop wrap cycles then flush_i together with wr_valid_i -> count_o 0, empty_o 1, no overrun; reset_n low mid-fill -> all outputs to reset values next cycle.
